// File: rtl/mat_pkg.sv
// mat_pkg: shared definitions for the packed-matrix result bus.
//   ELEM_W / N : default element width and matrix dimension
//   NN         : elements per matrix (N*N)
//   IDX_W      : width of a flat element index 0..NN-1
//   RC_W       : width of a row or column index 0..N-1
//   mat_t      : packed matrix, element k at [ELEM_W*k +: ELEM_W], row-major
//   beat_t     : one streamed element with its row/col/last tags
//   elem()     : slice element k out of a packed matrix
package mat_pkg;
  localparam int ELEM_W = 16;
  localparam int N      = 3;
  localparam int NN     = N * N;
  localparam int IDX_W  = $clog2(NN);
  localparam int RC_W   = $clog2(N);

  typedef logic [ELEM_W*NN-1:0] mat_t;
  typedef logic [ELEM_W-1:0]    elem_t;

  typedef struct packed {
    elem_t           data;
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
    logic            last;
  } beat_t;

  function automatic elem_t elem(input mat_t mat, input int k);
    return mat[k*ELEM_W +: ELEM_W];
  endfunction
endpackage

// File: rtl/mat_stream_tx_if.sv
// mat_stream_tx_if: input matrix handshake plus output element stream.
//   in_valid/in_ready/in_mat : one packed N*N matrix per handshake
//   out_valid/out_ready      : element stream handshake
//   out_data/out_row/out_col/out_last : current element and its tags
// Modports: master = producer of matrices / consumer of elements,
//           slave  = the transmitter.
interface mat_stream_tx_if #(
  parameter int ELEM_W = mat_pkg::ELEM_W,
  parameter int N      = mat_pkg::N
);
  localparam int RC_W = $clog2(N);

  logic                    in_valid;
  logic                    in_ready;
  logic [ELEM_W*N*N-1:0]   in_mat;
  logic                    out_valid;
  logic                    out_ready;
  logic [ELEM_W-1:0]       out_data;
  logic [RC_W-1:0]         out_row;
  logic [RC_W-1:0]         out_col;
  logic                    out_last;

  modport master (
    output in_valid, in_mat, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last
  );

  modport slave (
    input  in_valid, in_mat, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last
  );
endinterface

// File: rtl/mat_elem_mux.sv
// mat_elem_mux: combinational select of one element from a packed matrix.
//   i_mat  : packed N*N matrix, element k at [ELEM_W*k +: ELEM_W]
//   i_idx  : flat element index 0..N*N-1
//   o_data : selected element (zero for an out-of-range index)
module mat_elem_mux #(
  parameter int ELEM_W = mat_pkg::ELEM_W,
  parameter int N      = mat_pkg::N
) (
  input  logic [ELEM_W*N*N-1:0]     i_mat,
  input  logic [$clog2(N*N)-1:0]    i_idx,
  output logic [ELEM_W-1:0]         o_data
);
  localparam int NUM = N * N;
  localparam int IW  = $clog2(NUM);

  logic [ELEM_W-1:0] w_elems [NUM];

  for (genvar gi = 0; gi < NUM; gi++) begin : g_slice
    assign w_elems[gi] = i_mat[gi*ELEM_W +: ELEM_W];
  end

  // Compare-and-select keeps indices beyond NUM-1 from addressing past the array.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < NUM; k++) begin
      if (i_idx == IW'(k)) o_data = w_elems[k];
    end
  end
endmodule

// File: rtl/mat_stream_tx.sv
// mat_stream_tx: accepts packed N*N matrices and streams their elements
// one per beat, row-major, tagged with row, column and last.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : mat_stream_tx_if slave (matrix input, element output)
// Two matrix slots: active (being streamed) and pending (next in line),
// so a new matrix can be taken while the current one drains.
module mat_stream_tx #(
  parameter int ELEM_W = mat_pkg::ELEM_W,
  parameter int N      = mat_pkg::N
) (
  input logic            clk,
  input logic            rst,
  mat_stream_tx_if.slave bus
);
  localparam int NUM   = N * N;
  localparam int IW    = $clog2(NUM);
  localparam int CW    = $clog2(N);
  localparam int MAT_W = ELEM_W * NUM;

  logic [MAT_W-1:0] r_act_mat;
  logic [MAT_W-1:0] r_pend_mat;
  logic             r_act_valid;
  logic             r_pend_valid;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_row;
  logic [CW-1:0]    r_col;

  logic w_accept;
  logic w_fire;
  logic w_is_last;
  logic w_last_fire;

  // Readiness depends only on the pending slot, never on the handshakes.
  assign bus.in_ready = !r_pend_valid;
  assign w_accept     = bus.in_valid && !r_pend_valid;
  assign w_fire       = r_act_valid && bus.out_ready;
  assign w_is_last    = (r_idx == IW'(NUM - 1));
  assign w_last_fire  = w_fire && w_is_last;

  assign bus.out_valid = r_act_valid;
  assign bus.out_last  = r_act_valid && w_is_last;
  assign bus.out_row   = r_row;
  assign bus.out_col   = r_col;

  mat_elem_mux #(
    .ELEM_W (ELEM_W),
    .N      (N)
  ) u_mux (
    .i_mat  (r_act_mat),
    .i_idx  (r_idx),
    .o_data (bus.out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_mat    <= '0;
      r_pend_mat   <= '0;
      r_act_valid  <= 1'b0;
      r_pend_valid <= 1'b0;
      r_idx        <= '0;
      r_row        <= '0;
      r_col        <= '0;
    end else begin
      if (w_fire) begin
        if (w_is_last) begin
          r_idx <= '0;
          r_row <= '0;
          r_col <= '0;
          // Pending has priority; an accept cannot coincide with it because
          // in_ready is low whenever pending is full.
          if (r_pend_valid) begin
            r_act_mat    <= r_pend_mat;
            r_pend_valid <= 1'b0;
          end else if (w_accept) begin
            r_act_mat <= bus.in_mat;
          end else begin
            r_act_valid <= 1'b0;
          end
        end else begin
          r_idx <= r_idx + 1'b1;
          if (r_col == CW'(N - 1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      end

      // Accepts not already consumed by the last-beat handoff above.
      if (w_accept && !w_last_fire) begin
        if (!r_act_valid) begin
          r_act_mat   <= bus.in_mat;
          r_act_valid <= 1'b1;
        end else begin
          r_pend_mat   <= bus.in_mat;
          r_pend_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mat_stream_tx.sv
// tb_mat_stream_tx: directed and random stimulus for mat_stream_tx with a
// queue-based scoreboard. Every accepted matrix is expanded into its nine
// expected beats (value, row = k / N, col = k % N, last on k = NN-1) and a
// monitor pops one entry per fired beat.
module tb_mat_stream_tx;
  import mat_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mat_stream_tx_if #(.ELEM_W(ELEM_W), .N(N)) bus ();

  mat_stream_tx #(.ELEM_W(ELEM_W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  beat_t exp_q[$];
  int    fire_cyc[$];
  int    acc_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor / scoreboard, sampling mid-cycle on the falling edge.
  initial begin
    beat_t got, e, held;
    logic  stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        got.data = bus.out_data;
        got.row  = bus.out_row;
        got.col  = bus.out_col;
        got.last = bus.out_last;
        if (stall_prev) begin
          chk("hold_valid", 32'(bus.out_valid), 32'(1'b1));
          chk("hold_beat", 32'(got), 32'(held));
        end
        if (bus.out_valid && bus.out_ready) begin
          fire_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL sb_unexpected_beat: got data 0x%0h row %0d col %0d, expected no beat",
                     got.data, got.row, got.col);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(got.data), 32'(e.data));
            chk("beat_row",  32'(got.row),  32'(e.row));
            chk("beat_col",  32'(got.col),  32'(e.col));
            chk("beat_last", 32'(got.last), 32'(e.last));
            $display("[TB] beat data=0x%04h row=%0d col=%0d last=%0b", got.data, got.row, got.col, got.last);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          acc_cyc.push_back(cyc);
          $display("[TB] accept matrix at cycle %0d", cyc);
          for (int k = 0; k < NN; k++) begin
            e.data = elem(bus.in_mat, k);
            e.row  = RC_W'(k / N);
            e.col  = RC_W'(k % N);
            e.last = (k == NN - 1);
            exp_q.push_back(e);
          end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held = got;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input mat_t m);
    logic acc;
    int   g;
    acc = 1'b0;
    g = 0;
    bus.in_valid = 1'b1;
    bus.in_mat   = m;
    while (!acc && g < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      g++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL send_timeout: in_ready stayed 0, expected an accept");
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      tick();
      g++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
    tick();
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    for (int k = 0; k < NN; k++) m[k*ELEM_W +: ELEM_W] = elem_t'($urandom);
    return m;
  endfunction

  function automatic mat_t const_mat(input elem_t v);
    mat_t m;
    for (int k = 0; k < NN; k++) m[k*ELEM_W +: ELEM_W] = v;
    return m;
  endfunction

  initial begin
    mat_t m, ma, mb;
    mat_t mq[3];
    int   mi, a0, g;
    logic acc;

    bus.in_valid  = 1'b0;
    bus.in_mat    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
    chk("rst_out_data",  32'(bus.out_data),  32'(0));
    chk("rst_out_row",   32'(bus.out_row),   32'(0));
    chk("rst_out_col",   32'(bus.out_col),   32'(0));
    chk("rst_out_last",  32'(bus.out_last),  32'(1'b0));
    chk("rst_in_ready",  32'(bus.in_ready),  32'(1'b1));
    tick();

    // Single matrix, values k-4
    bus.out_ready = 1'b1;
    fire_cyc.delete(); acc_cyc.delete();
    for (int k = 0; k < NN; k++) m[k*ELEM_W +: ELEM_W] = elem_t'(k - 4);
    send(m);
    @(negedge clk);
    chk("t1_latency_valid", 32'(bus.out_valid), 32'(1'b1));
    repeat (9) tick();
    @(negedge clk);
    chk("t1_idle_after", 32'(bus.out_valid), 32'(1'b0));
    a0 = acc_cyc[0];
    chk("t1_fire_count", 32'(fire_cyc.size()), 32'(NN));
    chk("t1_first_beat_cyc", 32'(fire_cyc[0]), 32'(a0 + 1));
    chk("t1_last_beat_cyc", 32'(fire_cyc[NN-1]), 32'(a0 + NN));
    tick();

    // Back-to-back A then B
    fire_cyc.delete(); acc_cyc.delete();
    ma = const_mat(16'h0001);
    mb = const_mat(16'hFFFF);
    send(ma);
    send(mb);
    for (int i = 0; i < NN - 1; i++) begin
      @(negedge clk);
      chk("t2_in_ready_low", 32'(bus.in_ready), 32'(1'b0));
      tick();
    end
    @(negedge clk);
    chk("t2_in_ready_back", 32'(bus.in_ready), 32'(1'b1));
    drain();
    chk("t2_fire_count", 32'(fire_cyc.size()), 32'(2 * NN));
    chk("t2_no_gap", 32'(fire_cyc[2*NN-1] - fire_cyc[0]), 32'(2 * NN - 1));
    chk("t2_first_beat_cyc", 32'(fire_cyc[0]), 32'(acc_cyc[0] + 1));

    // Backpressure on element 2
    fire_cyc.delete(); acc_cyc.delete();
    send(rand_mat());
    tick(); tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t3_stall_col", 32'(bus.out_col), 32'(2));
    chk("t3_stall_valid", 32'(bus.out_valid), 32'(1'b1));
    repeat (4) tick();
    bus.out_ready = 1'b1;
    drain();
    a0 = acc_cyc[0];
    chk("t3_fire_count", 32'(fire_cyc.size()), 32'(NN));
    chk("t3_elem2_cyc", 32'(fire_cyc[2]), 32'(a0 + 7));
    chk("t3_elem3_follows", 32'(fire_cyc[3]), 32'(fire_cyc[2] + 1));

    // Full buffer: three offered while stalled
    fire_cyc.delete(); acc_cyc.delete();
    for (int i = 0; i < 3; i++) mq[i] = rand_mat();
    bus.out_ready = 1'b0;
    mi = 0;
    bus.in_valid = 1'b1;
    bus.in_mat = mq[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      if (acc && mi < 2) begin
        mi++;
        bus.in_mat = mq[mi];
      end
    end
    @(negedge clk);
    chk("t4_accepts_stalled", 32'(acc_cyc.size()), 32'(2));
    chk("t4_in_ready_full", 32'(bus.in_ready), 32'(1'b0));
    tick();
    bus.out_ready = 1'b1;
    g = 0;
    while (acc_cyc.size() < 3 && g < 100) begin
      tick();
      g++;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("t4_accept_count", 32'(acc_cyc.size()), 32'(3));
    chk("t4_fire_count", 32'(fire_cyc.size()), 32'(3 * NN));
    if (acc_cyc.size() == 3 && fire_cyc.size() >= NN)
      chk("t4_third_accept_cyc", 32'(acc_cyc[2]), 32'(fire_cyc[NN-1] + 1));

    // Sign / width extremes
    m = rand_mat();
    m[0 +: ELEM_W] = 16'h7FFF;
    m[(NN-1)*ELEM_W +: ELEM_W] = 16'h8000;
    send(m);
    @(negedge clk);
    chk("t5_beat0_data", 32'(bus.out_data), 32'(16'h7FFF));
    drain();

    // Reset mid-stream with pending full
    fire_cyc.delete(); acc_cyc.delete();
    send(const_mat(16'h1234));
    send(const_mat(16'h5678));
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", 32'(bus.out_valid), 32'(1'b0));
    chk("t6_in_ready_after_rst", 32'(bus.in_ready), 32'(1'b1));
    chk("t6_last_after_rst", 32'(bus.out_last), 32'(1'b0));
    tick();
    fire_cyc.delete(); acc_cyc.delete();
    send(rand_mat());
    @(negedge clk);
    chk("t6_restart_row", 32'(bus.out_row), 32'(0));
    chk("t6_restart_col", 32'(bus.out_col), 32'(0));
    drain();
    chk("t6_fire_count", 32'(fire_cyc.size()), 32'(NN));

    // Random traffic
    bus.in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.in_valid && $urandom_range(0, 99) < 40) begin
        bus.in_valid = 1'b1;
        bus.in_mat = rand_mat();
      end
      bus.out_ready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("final_sb_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mat_stream_tx.md
# mat_stream_tx

Transmitter side of the packed-matrix result bus. It accepts one packed N×N result matrix per handshake, in the same layout the matrix adder produces: element k at bits [ELEM_W·k+ELEM_W−1 : ELEM_W·k], row-major, k = row·N + col. It then streams the elements out one per beat over a valid/ready channel, tagging each beat with its row, column and last flag. A one-deep pending buffer lets the next matrix be accepted while the current one drains, so back-to-back matrices stream with no bubble.

## Interface
- ELEM_W, 16, width of one packed element in bits
- N, 3, matrix dimension; N·N elements per matrix; N ≥ 2
- clk  input  1  single clock; all logic rising-edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  packed matrix on in_mat is valid
- in_ready  output  1  transmitter can accept a matrix this cycle
- in_mat  input  ELEM_W·N·N  packed signed matrix; element 0 in the LSBs
- out_valid  output  1  out_* fields hold a valid element
- out_ready  input  1  downstream accepts the current element
- out_data  output  ELEM_W  signed element value, passed through unmodified
- out_row  output  clog2(N)  row index of out_data
- out_col  output  clog2(N)  column index of out_data
- out_last  output  1  high on the beat carrying element N·N−1

## Operation
- Storage: active register (matrix being sent, plus active_valid) and pending register (plus pending_valid). Beat counter idx is 0..N·N−1. The row and column counters advance with idx; out_row and out_col come from these counters, not from division.
- Accept: when in_valid && in_ready.
- in_ready = !pending_valid. It is combinational from state only and never depends on in_valid or out_ready.
- On accept, in_mat loads the active register when active becomes free this cycle. Active is free when it is empty, or when its last beat fires this cycle with pending empty. Otherwise in_mat loads the pending register.
- Beat fire: when out_valid && out_ready. On a non-last fire, idx advances by 1; col wraps N−1→0 and row increments on the wrap.
- On a last fire (idx = N·N−1):
  - If pending is valid, it moves to active, pending_valid clears, and idx, row and col reset to 0.
  - Else if an accept happens the same cycle, in_mat loads straight into active.
  - Else active_valid clears.
- out_valid = active_valid.
- out_data = active element idx.
- out_last = active_valid && idx == N·N−1.
- Stalling (out_ready low) holds every out_* field stable. Once out_valid is high it never drops without a fire.
- No arithmetic on data. Values are signed but copied bit-exact.

## Timing
- Reset: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, in_ready=1; active_valid, pending_valid and idx all 0. Reset asserted mid-matrix discards both buffers with no partial completion. in_ready is 1 on the first cycle after reset.
- Latency: a matrix accepted into an empty block in cycle t gives out_valid=1 with element 0 in cycle t+1.
- Throughput: 1 element per cycle with out_ready held high. Back-to-back matrices show no idle cycle between the last beat of one and element 0 of the next. Sustained input rate is 1 matrix per N·N cycles.
- Capacity: 2 matrices (active plus pending). in_ready drops the cycle after pending fills and rises the cycle after pending moves to active.
- Simultaneous accept and last fire with pending full cannot occur, because in_ready is 0.

## Structure
- Shared package mat_pkg holds ELEM_W and N defaults, the derived constants NN = N·N, IDX_W = clog2(NN) and RC_W = clog2(N), and the element-slice function elem(mat, k). The adder and the other matrix blocks use the same package.
- One sub-module, mat_elem_mux: combinational select of element idx from the packed active register. It is parameterised by ELEM_W and N and reusable by other readers of the packed bus.
- The control counters and the two buffers stay in mat_stream_tx.

## Test plan
- Single matrix, elements k = 0..8 with value k−4 (so −4..4), out_ready held 1 → 9 beats in cycles t+1..t+9 with out_data −4..4. (row, col) goes (0,0),(0,1),(0,2),(1,0)…(2,2). out_last is high only on the 9th beat. out_valid=0 at t+10.
- Two matrices offered back to back (A all 0x0001, B all 0xFFFF), out_ready=1 → 18 consecutive beats: A×9 then B×9, with no gap. in_ready=0 from the cycle after B is accepted until B moves to active.
- Backpressure: out_ready=0 for cycles 3–6 during element 2 → out_data, out_row, out_col and out_last hold stable with out_valid=1. Element 3 follows the cycle after out_ready returns high. Total of 9 fires.
- Full buffer: three matrices offered while out_ready=0 → only two accepts. in_ready stays 0 and the third stays offered until the first matrix's last beat fires.
- Sign and width check: element 8 = 0x8000 and element 0 = 0x7FFF → out_data 0x7FFF on beat 0 and 0x8000 on beat 8 with out_last=1, bit-exact.
- Reset mid-stream: rst for 1 cycle after beat 4 with pending full → next cycle out_valid=0 and in_ready=1. A new matrix then starts at element 0, (0,0).
